fp_result_buf: RTL and testbench
================================

FP_RESULT_BUF -- requirements
Module: fp_result_buf

Interface
REQ-001 The block SHALL have the following parameter:
- DEPTH, 4, number of buffered results; power of two, minimum 2.

REQ-002 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- input_z  input  32  IEEE-754 single-precision result from the upstream arithmetic stage.
- input_z_stb  input  1  one-cycle strobe marking input_z valid; no backpressure exists upstream.
- output_z  output  32  head-of-buffer result; 0 when empty.
- output_flags  output  4  head classification {nan, inf, zero, denorm}, bit 3 = nan; 0 when empty.
- output_z_stb  output  1  head valid (buffer non-empty).
- output_z_ack  input  1  consumer ready; a pop occurs when output_z_stb and output_z_ack are both high.
- count  output  clog2(DEPTH)+1  number of entries held.
- overflow  output  1  sticky flag: a result was dropped.
- clear_ovf  input  1  synchronous clear of overflow.

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH entries, each holding 32 data bits plus 4 flag bits.
REQ-004 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH without special-case logic.
REQ-005 Classification SHALL be computed from input_z at write time and stored with the entry:
- nan: exp==255 and mant!=0.
- inf: exp==255 and mant==0.
- zero: exp==0 and mant==0.
- denorm: exp==0 and mant!=0.
- Flags are one-hot or all-zero; the sign does not affect them.
REQ-006 A write SHALL occur on a rising edge where input_z_stb=1 and either count<DEPTH, or a pop occurs in the same cycle.
REQ-007 When input_z_stb=1, count==DEPTH and no pop occurs in that cycle, the input SHALL be dropped, storage and pointers unchanged, and overflow set to 1.
REQ-008 A simultaneous write and pop SHALL leave count unchanged and advance both pointers, including when count==DEPTH.
REQ-009 output_z_ack while output_z_stb=0 SHALL have no effect.
REQ-010 The buffer SHALL be first-word-fall-through:
- output_z, output_flags and output_z_stb are driven from registered state only.
- No combinational path exists from input_z/input_z_stb to any output.
REQ-011 Latency: a result written into an empty buffer at edge k SHALL appear on output_z with output_z_stb=1 during the cycle following edge k.
REQ-012 output_z_stb SHALL equal (count!=0); output_z and output_flags SHALL be 0 whenever count==0.
REQ-013 Results SHALL leave in strict arrival order, each exactly once.
REQ-014 clear_ovf=1 SHALL clear overflow at the next edge, unless a drop occurs in the same cycle, in which case overflow SHALL remain 1.
REQ-015 Throughput: with output_z_ack held high, the block SHALL sustain one write and one pop per cycle indefinitely.

Reset
REQ-016 Asserting rst SHALL immediately, without waiting for clk, force:
- count=0, both pointers=0, overflow=0.
- output_z_stb=0, output_z=0, output_flags=0.
REQ-017 Storage contents need not be cleared by reset, and SHALL never be observable while count==0.
REQ-018 Reset asserted mid-operation SHALL discard all held entries; no pop or write SHALL be reported on the edge coincident with deassertion if rst is still high at that edge.

Verification
REQ-019 Single item: after reset, strobe 32'h3F800000 once with ack=0 -> next cycle output_z_stb=1, output_z=32'h3F800000, flags=4'b0000, count=1; pulse ack -> count=0, output_z=0.
REQ-020 Classification: strobe 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000001 -> popped flags 4'b1000, 4'b0100, 4'b0010, 4'b0001 in order.
REQ-021 Overflow: DEPTH=4, ack=0, strobe 5 values 1..5 -> count=4, overflow=1, pops yield 1,2,3,4; clear_ovf -> overflow=0.
REQ-022 Full with simultaneous pop: fill 4 entries, then strobe value 9 with ack=1 in the same cycle -> count stays 4, overflow=0, value 9 is the last popped.
REQ-023 Streaming and wrap: ack=1, strobe 10 consecutive values over 10 cycles -> each appears one cycle later, count never exceeds 1, pointers wrap twice, no overflow.
REQ-024 Async reset: with 3 entries held, assert rst between clock edges -> outputs go to 0 and count=0 before the next clk edge.

Source files
------------

// File: rtl/fp_result_buf.sv
// fp_result_buf: first-word-fall-through circular buffer of FP results with per-entry classification flags
module fp_result_buf #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              input_z,
    input  logic                     input_z_stb,
    output logic [31:0]              output_z,
    output logic [3:0]               output_flags,
    output logic                     output_z_stb,
    input  logic                     output_z_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [35:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop, full, wr, drop;
    logic [7:0]    exp_in;
    logic          mant_nz;
    logic [3:0]    flags_in;

    // Classify the incoming result as {nan, inf, zero, denorm}; sign is ignored
    always_comb begin
        exp_in   = input_z[30:23];
        mant_nz  = |input_z[22:0];
        flags_in = {exp_in == 8'hFF && mant_nz, exp_in == 8'hFF && !mant_nz,
                    exp_in == 8'h00 && !mant_nz, exp_in == 8'h00 && mant_nz};
    end

    // Handshake decode and next-state: a pop frees a slot for a same-cycle write even when full
    always_comb begin
        pop      = (count_q != '0) && output_z_ack;
        full     = count_q == CW'(DEPTH);
        wr       = input_z_stb && (!full || pop);
        drop     = input_z_stb && full && !pop;
        wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr) - CW'(pop);
        ovf_d    = drop || (ovf_q && !clear_ovf);
    end

    // Pointer, occupancy and sticky overflow state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage is not reset; it is masked at the outputs whenever the buffer is empty
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {input_z, flags_in};
    end

    assign output_z_stb = count_q != '0;
    assign output_z     = output_z_stb ? mem_q[rd_ptr_q][35:4] : 32'h0;
    assign output_flags = output_z_stb ? mem_q[rd_ptr_q][3:0] : 4'h0;
    assign count        = count_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_fp_result_buf.sv
// tb_fp_result_buf: scoreboard bench for fp_result_buf
module tb_fp_result_buf;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_z = '0;
    logic        input_z_stb = 1'b0;
    logic [31:0] output_z;
    logic [3:0]  output_flags;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;
    logic [2:0]  count;
    logic        overflow;
    logic        clear_ovf = 1'b0;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [35:0] exp_q [$];

    fp_result_buf #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .input_z(input_z), .input_z_stb(input_z_stb),
        .output_z(output_z), .output_flags(output_flags), .output_z_stb(output_z_stb),
        .output_z_ack(output_z_ack), .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [31:0] v, input logic [3:0] f, input bit kept);
        input_z = v;
        input_z_stb = 1'b1;
        if (kept) exp_q.push_back({v, f});
        @(posedge clk);
        #1;
        input_z_stb = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (count != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(count), 32'd0);
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (!rst && output_z_stb && output_z_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", output_z, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", output_z, e[35:4]);
                    check("pop_flags", 32'(output_flags), 32'(e[3:0]));
                end
            end else if (!rst && !output_z_stb) begin
                check("empty_outputs", {output_z[31:4], output_z[3:0] | output_flags}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_stb", 32'(output_z_stb), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_z", output_z, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single item with first-word-fall-through latency
        strobe(32'h3F800000, 4'b0000, 1);
        check("single_stb", 32'(output_z_stb), 32'd1);
        check("single_z", output_z, 32'h3F800000);
        check("single_flags", 32'(output_flags), 32'd0);
        check("single_count", 32'(count), 32'd1);
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
        check("single_popped_count", 32'(count), 32'd0);
        check("single_popped_z", output_z, 32'h0);

        // Classification of nan, -inf, -0, smallest denorm
        strobe(32'h7FC00000, 4'b1000, 1);
        strobe(32'hFF800000, 4'b0100, 1);
        strobe(32'h80000000, 4'b0010, 1);
        strobe(32'h00000001, 4'b0001, 1);
        check("class_count", 32'(count), 32'd4);
        output_z_ack = 1'b1;
        wait_empty();
        output_z_ack = 1'b0;

        // Overflow: fifth value dropped
        for (int i = 1; i <= 5; i++) strobe(32'(i), 4'b0001, i <= 4);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        // clear_ovf coincident with another drop keeps overflow set
        clear_ovf = 1'b1;
        strobe(32'h00000006, 4'b0001, 0);
        clear_ovf = 1'b0;
        check("ovf_clear_vs_drop", 32'(overflow), 32'd1);
        output_z_ack = 1'b1;
        wait_empty();
        output_z_ack = 1'b0;
        check("ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        @(posedge clk);
        #1;
        clear_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous pop and write
        for (int i = 0; i < 4; i++) strobe(32'h40000000 + 32'(i), 4'b0000, 1);
        output_z_ack = 1'b1;
        strobe(32'h00000009, 4'b0001, 1);
        check("full_pop_count", 32'(count), 32'd4);
        check("full_pop_ovf", 32'(overflow), 32'd0);
        wait_empty();

        // Streaming with ack high; pointers wrap
        for (int i = 0; i < 10; i++) begin
            strobe(32'h41000000 + 32'(i), 4'b0000, 1);
            check("stream_count", 32'(count), 32'd1);
            check("stream_z", output_z, 32'h41000000 + 32'(i));
        end
        @(posedge clk);
        #1;
        check("stream_end_count", 32'(count), 32'd0);
        check("stream_ovf", 32'(overflow), 32'd0);
        output_z_ack = 1'b0;

        // Asynchronous reset between edges discards held entries
        for (int i = 0; i < 3; i++) strobe(32'h42000000 + 32'(i), 4'b0000, 0);
        check("pre_rst_count", 32'(count), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_stb", 32'(output_z_stb), 32'd0);
        check("async_z", output_z, 32'h0);
        check("async_flags", 32'(output_flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_count", 32'(count), 32'd0);
        strobe(32'h7F800000, 4'b0100, 1);
        check("post_rst_z", output_z, 32'h7F800000);
        output_z_ack = 1'b1;
        wait_empty();
        output_z_ack = 1'b0;

        @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
